pixel_scan_gen: RTL and testbench

PIXEL_SCAN_GEN -- requirements
Module: pixel_scan_gen

---
 rtl/pixel_scan_gen_pkg.sv | 15 +
 rtl/pixel_scan_gen.sv | 159 +++++++++++++++
 tb/tb_pixel_scan_gen.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_scan_gen_pkg.sv
// ----------------------------------------------------------------------------
// pixel_scan_gen_pkg
//   Common definitions shared by the pixel scan generator and its users.
//   DEF_COORD_W   : default coordinate word width
//   DEF_FRAC_BITS : default fractional bits of emitted coordinates (Q11.21)
//   fp_t          : fixed-point coordinate word at the default width
// ----------------------------------------------------------------------------
package pixel_scan_gen_pkg;

    localparam int DEF_COORD_W   = 32;
    localparam int DEF_FRAC_BITS = 21;

    typedef logic [DEF_COORD_W-1:0] fp_t;

endpackage : pixel_scan_gen_pkg

// File: rtl/pixel_scan_gen.sv
// ----------------------------------------------------------------------------
// pixel_scan_gen
//   Walks a WIDTH x HEIGHT screen in raster order and hands each pixel's
//   fixed-point (x, y) to a ray pipeline over a valid/ready handshake. The
//   number of issued-but-unreturned pixels is bounded by MAX_INFLIGHT; the
//   frame completes once every issued pixel has come back on ret_valid.
//
// Ports
//   clk, rst_gen       clock, asynchronous active-low reset
//   start              one-cycle frame request (honoured only when idle)
//   continuous         loaded into the repeat latch on start
//   stop               clears the repeat latch; current frame still completes
//   coord_x/coord_y    pixel position, x << FRAC_BITS / y << FRAC_BITS
//   coord_valid/ready  handshake towards the ray pipeline
//   coord_sof          pixel (0,0)
//   coord_eol          last pixel of a line
//   ret_valid          one pixel returned by the ray pipeline
//   inflight           issued-but-unreturned pixel count
//   busy               generator not idle
//   frame_done         one-cycle pulse when the frame has fully drained
//   underflow_err      sticky: a return arrived with nothing outstanding
// ----------------------------------------------------------------------------
module pixel_scan_gen
    import pixel_scan_gen_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int COORD_W      = DEF_COORD_W,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              rst_gen,
    input  logic                              start,
    input  logic                              continuous,
    input  logic                              stop,
    output logic [COORD_W-1:0]                coord_x,
    output logic [COORD_W-1:0]                coord_y,
    output logic                              coord_valid,
    input  logic                              coord_ready,
    output logic                              coord_sof,
    output logic                              coord_eol,
    input  logic                              ret_valid,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              underflow_err
);

    localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW    = $clog2(MAX_INFLIGHT + 1);
    localparam int INT_W = COORD_W - FRAC_BITS - 1;

    // The integer part keeps one spare bit below the word's top bit, so the
    // largest coordinate must fit in INT_W bits.
    if (INT_W < 1 || ((WIDTH - 1) >> INT_W) != 0 || ((HEIGHT - 1) >> INT_W) != 0
        || WIDTH < 1 || HEIGHT < 1 || MAX_INFLIGHT < 1) begin : g_bad_cfg
        $error("pixel_scan_gen: WIDTH/HEIGHT do not fit the integer part of COORD_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } scan_state_e;

    scan_state_e   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          repeat_q, repeat_d;
    logic          underflow_q, underflow_d;

    logic          xfer;
    logic          x_last;
    logic          y_last;
    logic          drain_exit;

    // Valid depends on registered state only, so the ready input never
    // reaches coord_valid combinationally.
    assign coord_valid = (state_q == S_RUN) && (inflight_q < IW'(MAX_INFLIGHT));
    assign xfer        = coord_valid && coord_ready;
    assign x_last      = (x_q == XW'(WIDTH - 1));
    assign y_last      = (y_q == YW'(HEIGHT - 1));
    assign drain_exit  = (state_q == S_DRAIN) && (inflight_q == '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        inflight_d  = inflight_q;
        repeat_d    = repeat_q;
        underflow_d = underflow_q;

        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (xfer && x_last && y_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_exit) state_d = (repeat_q && !stop) ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Raster advance; the wrap after the last pixel leaves x=y=0 ready
        // for the next frame, whether it starts from IDLE or straight after DRAIN.
        if (xfer) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        // A simultaneous issue and return cancel out.
        case ({xfer, ret_valid})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01: begin
                if (inflight_q == '0) underflow_d = 1'b1;
                else                  inflight_d  = inflight_q - IW'(1);
            end
            default: inflight_d = inflight_q;
        endcase

        if (state_q == S_IDLE && start) repeat_d = continuous;
        if (stop)                       repeat_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            inflight_q  <= '0;
            repeat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            inflight_q  <= inflight_d;
            repeat_q    <= repeat_d;
            underflow_q <= underflow_d;
        end
    end

    assign coord_x       = COORD_W'(x_q) << FRAC_BITS;
    assign coord_y       = COORD_W'(y_q) << FRAC_BITS;
    assign coord_sof     = (x_q == '0) && (y_q == '0);
    assign coord_eol     = x_last;
    assign inflight      = inflight_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = drain_exit;
    assign underflow_err = underflow_q;

endmodule : pixel_scan_gen

// File: tb/tb_pixel_scan_gen.sv
// ----------------------------------------------------------------------------
// tb_pixel_scan_gen
//   Self-checking bench for pixel_scan_gen at WIDTH=4, HEIGHT=3,
//   MAX_INFLIGHT=2. Expected pixels are queued per frame and popped on each
//   observed transfer; a cycle table exercises the in-flight limit.
// ----------------------------------------------------------------------------
module tb_pixel_scan_gen;
    import pixel_scan_gen_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int MI = 2;
    localparam int FB = 21;
    localparam int CW = 32;
    localparam int IW = $clog2(MI + 1);

    logic          clk         = 1'b0;
    logic          rst_gen     = 1'b1;
    logic          start       = 1'b0;
    logic          continuous  = 1'b0;
    logic          stop        = 1'b0;
    logic          coord_ready = 1'b0;
    logic          ret_manual  = 1'b0;
    logic          auto_en     = 1'b0;
    logic [CW-1:0] coord_x;
    logic [CW-1:0] coord_y;
    logic          coord_valid;
    logic          coord_sof;
    logic          coord_eol;
    logic          ret_valid;
    logic [IW-1:0] inflight;
    logic          busy;
    logic          frame_done;
    logic          underflow_err;
    logic [2:0]    ret_pipe;

    pixel_scan_gen #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .FRAC_BITS    (FB),
        .COORD_W      (CW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk           (clk),
        .rst_gen       (rst_gen),
        .start         (start),
        .continuous    (continuous),
        .stop          (stop),
        .coord_x       (coord_x),
        .coord_y       (coord_y),
        .coord_valid   (coord_valid),
        .coord_ready   (coord_ready),
        .coord_sof     (coord_sof),
        .coord_eol     (coord_eol),
        .ret_valid     (ret_valid),
        .inflight      (inflight),
        .busy          (busy),
        .frame_done    (frame_done),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    // Ray pipeline stand-in: each transfer returns three cycles later.
    always @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) ret_pipe <= '0;
        else          ret_pipe <= {ret_pipe[1:0], coord_valid & coord_ready};
    end
    assign ret_valid = ret_manual | (auto_en & ret_pipe[2]);

    typedef struct {
        int x;
        int y;
        bit sof;
        bit eol;
    } pix_t;

    typedef struct {
        bit ready;
        bit ret;
        bit exp_valid;
        int exp_inflight;
    } vec_t;

    pix_t exp_q[$];
    vec_t vecs[12];

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int sof_cnt  = 0;
    int eol_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back('{x, y, (x == 0 && y == 0), (x == W - 1)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        i = 0;
        while (done_cnt < target && i < budget) begin
            tick();
            i++;
        end
        check("frame_done_count", done_cnt, target);
    endtask

    // Scoreboard and handshake-stability monitor, sampled mid-cycle.
    task automatic monitor();
        bit            stalled;
        logic [CW-1:0] hx, hy;
        logic          hs, he;
        pix_t          e;
        fp_t           ex, ey;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_gen) begin
                if (stalled && coord_valid) begin
                    check("hold_x", coord_x, hx);
                    check("hold_y", coord_y, hy);
                    check("hold_sof", coord_sof, hs);
                    check("hold_eol", coord_eol, he);
                end
                if (frame_done) done_cnt++;
                if (coord_valid && coord_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", exp_q.size(), 1);
                    end else begin
                        e  = exp_q.pop_front();
                        ex = fp_t'(e.x) << FB;
                        ey = fp_t'(e.y) << FB;
                        check("coord_x", coord_x, ex);
                        check("coord_y", coord_y, ey);
                        check("coord_sof", coord_sof, e.sof);
                        check("coord_eol", coord_eol, e.eol);
                        if (e.x == 3 && e.y == 1) check("x_of_pixel_3_1", coord_x, 32'h0060_0000);
                        if (coord_sof) sof_cnt++;
                        if (coord_eol) eol_cnt++;
                    end
                end
                stalled = coord_valid && !coord_ready;
                hx = coord_x;
                hy = coord_y;
                hs = coord_sof;
                he = coord_eol;
            end else begin
                stalled = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int base;
        int guard;

        // {ready, ret, expected coord_valid, expected inflight} per cycle
        vecs[0]  = '{1, 0, 1, 0};
        vecs[1]  = '{1, 0, 1, 1};
        vecs[2]  = '{1, 0, 0, 2};
        vecs[3]  = '{1, 0, 0, 2};
        vecs[4]  = '{0, 1, 0, 2};
        vecs[5]  = '{1, 0, 1, 1};
        vecs[6]  = '{1, 0, 0, 2};
        vecs[7]  = '{1, 1, 0, 2};
        vecs[8]  = '{1, 1, 1, 1};
        vecs[9]  = '{0, 0, 1, 1};
        vecs[10] = '{0, 1, 1, 1};
        vecs[11] = '{0, 0, 1, 0};

        fork
            monitor();
        join_none

        // Reset values
        #1 rst_gen = 1'b0;
        #2;
        check("rst_valid", coord_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_inflight", inflight, 0);
        check("rst_underflow", underflow_err, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_coord_x", coord_x, 0);
        tick(2);
        rst_gen = 1'b1;
        tick();

        // Single frame, steady returns
        coord_ready = 1'b1;
        auto_en     = 1'b1;
        push_frame();
        pulse_start();
        check("first_valid", coord_valid, 1);
        check("first_sof", coord_sof, 1);
        check("first_busy", busy, 1);
        wait_done(1, 300);
        check("f1_idle", busy, 0);
        check("f1_xfers", xfer_cnt, 12);
        check("f1_sof_cnt", sof_cnt, 1);
        check("f1_eol_cnt", eol_cnt, 3);
        check("f1_queue_empty", exp_q.size(), 0);
        check("f1_inflight", inflight, 0);

        // In-flight limit and simultaneous issue/return
        auto_en     = 1'b0;
        coord_ready = 1'b0;
        push_frame();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            coord_ready = vecs[i].ready;
            ret_manual  = vecs[i].ret;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), coord_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_inflight", i), inflight, vecs[i].exp_inflight);
            tick();
        end
        coord_ready = 1'b0;
        ret_manual  = 1'b0;
        tick();
        check("vec_no_underflow", underflow_err, 0);
        auto_en     = 1'b1;
        coord_ready = 1'b1;
        wait_done(2, 300);
        check("f2_queue_empty", exp_q.size(), 0);

        // Ready held low mid-line
        push_frame();
        pulse_start();
        tick(4);
        coord_ready = 1'b0;
        tick(5);
        check("stall_valid", coord_valid, 1);
        coord_ready = 1'b1;
        wait_done(3, 300);
        check("f3_queue_empty", exp_q.size(), 0);

        // Continuous frames, stop during the second
        continuous = 1'b1;
        push_frame();
        push_frame();
        pulse_start();
        continuous = 1'b0;
        wait_done(4, 300);
        check("cont_busy", busy, 1);
        check("cont_valid", coord_valid, 1);
        check("cont_sof", coord_sof, 1);
        tick(4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(5, 300);
        check("cont_idle", busy, 0);
        tick(20);
        check("cont_no_extra_frame", done_cnt, 5);
        check("cont_still_idle", busy, 0);
        check("cont_queue_empty", exp_q.size(), 0);

        // Return while idle
        check("pre_underflow", underflow_err, 0);
        ret_manual = 1'b1;
        tick();
        ret_manual = 1'b0;
        check("underflow_set", underflow_err, 1);
        check("underflow_inflight", inflight, 0);
        tick(3);
        check("underflow_sticky", underflow_err, 1);

        // Reset during pixel 6
        push_frame();
        base = xfer_cnt;
        pulse_start();
        guard = 0;
        while (xfer_cnt - base < 5 && guard < 100) begin
            tick();
            guard++;
        end
        check("reached_pixel6", xfer_cnt - base, 5);
        #2 rst_gen = 1'b0;
        #1;
        check("mid_rst_valid", coord_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_inflight", inflight, 0);
        check("mid_rst_underflow", underflow_err, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_x", coord_x, 0);
        check("mid_rst_y", coord_y, 0);
        exp_q.delete();
        auto_en = 1'b0;
        tick(2);
        rst_gen = 1'b1;
        tick();
        check("mid_rst_no_done", done_cnt, 5);
        ret_manual = 1'b1;
        tick();
        ret_manual = 1'b0;
        check("abandoned_ret_underflow", underflow_err, 1);
        auto_en = 1'b1;
        push_frame();
        pulse_start();
        check("restart_x", coord_x, 0);
        check("restart_y", coord_y, 0);
        check("restart_sof", coord_sof, 1);
        wait_done(6, 300);
        check("f_restart_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pixel_scan_gen
